param_regfile: RTL and testbench
================================

PARAM_REGFILE -- requirements
Module: param_regfile

Interface
REQ-001 Parameter NUM_BYTES, default 55, bytes per parameter frame.
REQ-002 Parameter IDX_W, default 6, width of byte index.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 update_reg  input  1  one-cycle strobe: read_data/idx valid.
REQ-006 read_data  input  8  received parameter byte.
REQ-007 idx  input  IDX_W  byte index within frame, 0..NUM_BYTES-1.
REQ-008 pc_ready  input  1  one-cycle end-of-frame strobe.
REQ-009 vsync  input  1  one-cycle display frame boundary; only commit point.
REQ-010 rd_addr  input  IDX_W  active-bank byte read address.
REQ-011 rd_data  output  8  registered active-bank byte.
REQ-012 params_out  output  8*NUM_BYTES  flattened active bank; byte k at bits [8k+7:8k].
REQ-013 params_valid  output  1  high once any frame has committed.
REQ-014 commit_pulse  output  1  one-cycle strobe on active-bank update.
REQ-015 frame_err  output  1  sticky error flag.
REQ-016 frame_count  output  8  committed-frame counter.

Function
REQ-017 Two banks: shadow (written by input stream), active (drives outputs); states IDLE, FILL, PENDING.
REQ-018 IDLE: update_reg with idx==0 -> write shadow[0], expected=1, clear frame checks, go FILL; update_reg with idx!=0 -> byte dropped, frame_err=1.
REQ-019 FILL: update_reg with idx==expected -> write shadow[idx], expected+1.
REQ-020 FILL: update_reg with idx==0 -> frame restarts exactly as REQ-018 (partial frame discarded, no error).
REQ-021 FILL: update_reg with other idx, including idx>=NUM_BYTES -> byte dropped, seq_err latched for this frame.
REQ-022 FILL: pc_ready with expected==NUM_BYTES and no seq_err -> PENDING; otherwise frame_err=1, go IDLE.
REQ-023 pc_ready in IDLE or PENDING -> ignored, frame_err=1.
REQ-024 PENDING: update_reg dropped, frame_err=1; vsync -> copy shadow to active in one cycle, commit_pulse=1 next cycle, params_valid=1, frame_count+1 (255 wraps to 0), frame_err=0, go IDLE.
REQ-025 vsync coincident with the pc_ready that enters PENDING does not commit; next vsync commits.
REQ-026 vsync in IDLE/FILL has no effect.
REQ-027 rd_data = active[rd_addr] one cycle after rd_addr; rd_addr>=NUM_BYTES returns 0x00.
REQ-028 params_out changes only on commit; never shows a partial frame.

Reset
REQ-029 Reset: both banks 0, state IDLE, expected 0, rd_data 0, params_valid 0, commit_pulse 0, frame_err 0, frame_count 0.
REQ-030 Reset mid-frame or in PENDING discards the shadow frame; active bank cleared.

Configuration
REQ-031 Macro PARAM_CSUM_EN defined: byte NUM_BYTES-1 must equal XOR of bytes 0..NUM_BYTES-2; mismatch at pc_ready treated as REQ-022 failure (frame_err=1, IDLE); byte still stored in bank.
REQ-032 PARAM_CSUM_EN undefined: no checksum logic; last byte is plain data.

Structure
REQ-033 Package gpu_param_pkg holds NUM_BYTES, IDX_W defaults, and state encoding.
REQ-034 Sub-module param_bank: NUM_BYTES x 8 storage with byte write port, bulk load, registered read port; instantiated twice.

Verification
REQ-035 Reset; bytes 0..54 value=idx in order, pc_ready, vsync -> commit_pulse 1 cycle, params_out byte 10=0x0A, frame_count=1, params_valid=1.
REQ-036 Frame with idx 7 skipped, pc_ready -> frame_err=1, no commit_pulse on following vsync, params_out unchanged.
REQ-037 Good frame, pc_ready, 3 vsync-free cycles, then bytes arrive -> dropped, frame_err=1; vsync still commits original frame, frame_err cleared.
REQ-038 vsync same cycle as pc_ready -> no commit; next vsync -> commit; 256 good frames -> frame_count wraps to 0.
REQ-039 rd_addr=3 -> rd_data=active[3] next cycle; rd_addr=60 -> 0x00.
REQ-040 PARAM_CSUM_EN: byte 54 = XOR(0..53) commits; byte 54 corrupted -> frame_err=1, no commit.

Source files
------------

// File: rtl/gpu_param_pkg.sv
// Shared defaults and FSM state encoding for the parameter register file.
package gpu_param_pkg;

    localparam int unsigned NUM_BYTES_DEFAULT = 55;
    localparam int unsigned IDX_W_DEFAULT     = 6;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFill    = 2'd1,
        StPending = 2'd2
    } state_e;

endpackage

// File: rtl/param_bank.sv
// NUM_BYTES x 8 byte store: single-byte write port, whole-bank load, registered read port.
// Out-of-range read addresses return 0x00.
module param_bank
    import gpu_param_pkg::*;
#(
    parameter int unsigned NUM_BYTES = NUM_BYTES_DEFAULT,
    parameter int unsigned IDX_W     = IDX_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_addr,
    input  logic [7:0]             wr_data,
    input  logic                   load_en,
    input  logic [8*NUM_BYTES-1:0] load_data,
    input  logic [IDX_W-1:0]       rd_addr,
    output logic [7:0]             rd_data,
    output logic [8*NUM_BYTES-1:0] contents
);

    logic [8*NUM_BYTES-1:0] mem_q, mem_d;
    logic [7:0]             rd_data_q, rd_data_d;

    always_comb begin
        mem_d = mem_q;
        if (load_en) begin
            mem_d = load_data;
        end else if (wr_en) begin
            for (int k = 0; k < int'(NUM_BYTES); k++) begin
                if (wr_addr == IDX_W'(k)) begin
                    mem_d[8*k +: 8] = wr_data;
                end
            end
        end
    end

    // No match leaves the default, so addresses past the bank read as zero.
    always_comb begin
        rd_data_d = 8'h00;
        for (int k = 0; k < int'(NUM_BYTES); k++) begin
            if (rd_addr == IDX_W'(k)) begin
                rd_data_d = mem_q[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q     <= '0;
            rd_data_q <= 8'h00;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign contents = mem_q;

endmodule

// File: rtl/param_regfile.sv
// Double-buffered parameter register file: bytes fill a shadow bank, vsync commits it to the
// active bank. Define PARAM_CSUM_EN to require the last byte to be the XOR of all others.
module param_regfile
    import gpu_param_pkg::*;
#(
    parameter int unsigned NUM_BYTES = NUM_BYTES_DEFAULT,
    parameter int unsigned IDX_W     = IDX_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   update_reg,
    input  logic [7:0]             read_data,
    input  logic [IDX_W-1:0]       idx,
    input  logic                   pc_ready,
    input  logic                   vsync,
    input  logic [IDX_W-1:0]       rd_addr,
    output logic [7:0]             rd_data,
    output logic [8*NUM_BYTES-1:0] params_out,
    output logic                   params_valid,
    output logic                   commit_pulse,
    output logic                   frame_err,
    output logic [7:0]             frame_count
);

    localparam logic [IDX_W:0] LAST = (IDX_W+1)'(NUM_BYTES);

    state_e         state_q, state_d;
    logic [IDX_W:0] expected_q, expected_d;
    logic           seq_err_q, seq_err_d;
    logic           frame_err_q, frame_err_d;
    logic           valid_q, valid_d;
    logic           commit_q, commit_d;
    logic [7:0]     count_q, count_d;

    logic                   shadow_wr;
    logic                   bank_load;
    logic                   csum_ok;
    logic [IDX_W:0]         idx_ext;
    logic [8*NUM_BYTES-1:0] shadow_contents;
    logic [7:0]             unused_shadow_rd;

    assign idx_ext = {1'b0, idx};

`ifdef PARAM_CSUM_EN
    // XOR over the whole frame including the check byte is zero exactly when the check holds.
    logic [7:0] csum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= 8'h00;
        end else if (shadow_wr) begin
            csum_q <= (idx == '0) ? read_data : (csum_q ^ read_data);
        end
    end

    assign csum_ok = (csum_q == 8'h00);
`else
    assign csum_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        seq_err_d   = seq_err_q;
        frame_err_d = frame_err_q;
        valid_d     = valid_q;
        count_d     = count_q;
        commit_d    = 1'b0;
        shadow_wr   = 1'b0;
        bank_load   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pc_ready) begin
                    frame_err_d = 1'b1;
                end
                if (update_reg) begin
                    if (idx == '0) begin
                        shadow_wr  = 1'b1;
                        expected_d = (IDX_W+1)'(1);
                        seq_err_d  = 1'b0;
                        state_d    = StFill;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            StFill: begin
                if (update_reg) begin
                    if (idx == '0) begin
                        shadow_wr  = 1'b1;
                        expected_d = (IDX_W+1)'(1);
                        seq_err_d  = 1'b0;
                    end else if (idx_ext == expected_q && expected_q < LAST) begin
                        shadow_wr  = 1'b1;
                        expected_d = expected_q + (IDX_W+1)'(1);
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
                // End of frame is judged on the bytes accepted before this cycle.
                if (pc_ready) begin
                    if (expected_q == LAST && !seq_err_q && csum_ok) begin
                        state_d = StPending;
                    end else begin
                        frame_err_d = 1'b1;
                        expected_d  = '0;
                        state_d     = StIdle;
                    end
                end
            end
            StPending: begin
                if (update_reg || pc_ready) begin
                    frame_err_d = 1'b1;
                end
                if (vsync) begin
                    bank_load   = 1'b1;
                    commit_d    = 1'b1;
                    valid_d     = 1'b1;
                    count_d     = count_q + 8'd1;
                    frame_err_d = 1'b0;
                    expected_d  = '0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            expected_q  <= '0;
            seq_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            valid_q     <= 1'b0;
            commit_q    <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            seq_err_q   <= seq_err_d;
            frame_err_q <= frame_err_d;
            valid_q     <= valid_d;
            commit_q    <= commit_d;
            count_q     <= count_d;
        end
    end

    param_bank #(
        .NUM_BYTES (NUM_BYTES),
        .IDX_W     (IDX_W)
    ) u_shadow (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (shadow_wr),
        .wr_addr   (idx),
        .wr_data   (read_data),
        .load_en   (1'b0),
        .load_data ('0),
        .rd_addr   ('0),
        .rd_data   (unused_shadow_rd),
        .contents  (shadow_contents)
    );

    param_bank #(
        .NUM_BYTES (NUM_BYTES),
        .IDX_W     (IDX_W)
    ) u_active (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (1'b0),
        .wr_addr   ('0),
        .wr_data   (8'h00),
        .load_en   (bank_load),
        .load_data (shadow_contents),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .contents  (params_out)
    );

    assign params_valid = valid_q;
    assign commit_pulse = commit_q;
    assign frame_err    = frame_err_q;
    assign frame_count  = count_q;

endmodule

// File: tb/tb_param_regfile.sv
// Directed self-checking bench for param_regfile (honours PARAM_CSUM_EN when defined).
module tb_param_regfile;

    localparam int NB = 55;
    localparam int IW = 6;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            update_reg = 1'b0;
    logic [7:0]      read_data = 8'h00;
    logic [IW-1:0]   idx = '0;
    logic            pc_ready = 1'b0;
    logic            vsync = 1'b0;
    logic [IW-1:0]   rd_addr = '0;
    logic [7:0]      rd_data;
    logic [8*NB-1:0] params_out;
    logic            params_valid;
    logic            commit_pulse;
    logic            frame_err;
    logic [7:0]      frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]      frm [NB];
    logic [8*NB-1:0] exp_active = '0;

    param_regfile #(
        .NUM_BYTES (NB),
        .IDX_W     (IW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .update_reg   (update_reg),
        .read_data    (read_data),
        .idx          (idx),
        .pc_ready     (pc_ready),
        .vsync        (vsync),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .params_out   (params_out),
        .params_valid (params_valid),
        .commit_pulse (commit_pulse),
        .frame_err    (frame_err),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_frame(input logic [7:0] base);
        for (int i = 0; i < NB; i++) frm[i] = 8'(i) + base;
`ifdef PARAM_CSUM_EN
        frm[NB-1] = 8'h00;
        for (int i = 0; i < NB - 1; i++) frm[NB-1] = frm[NB-1] ^ frm[i];
`endif
    endtask

    function automatic logic [8*NB-1:0] pack_frame();
        logic [8*NB-1:0] r;
        for (int i = 0; i < NB; i++) r[8*i +: 8] = frm[i];
        return r;
    endfunction

    task automatic send_byte(input int i, input logic [7:0] v);
        update_reg = 1'b1;
        idx        = IW'(i);
        read_data  = v;
        cycle();
        update_reg = 1'b0;
    endtask

    task automatic send_frame(input int skip);
        for (int i = 0; i < NB; i++) if (i != skip) send_byte(i, frm[i]);
    endtask

    task automatic pulse_pc();
        pc_ready = 1'b1;
        cycle();
        pc_ready = 1'b0;
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        cycle();
        vsync = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        exp_active = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 5;
        if (params_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", params_valid);
        end
        if (commit_pulse !== 1'b0) begin
            n_fail++; $display("FAIL reset_commit: got %b want 0", commit_pulse);
        end
        if (frame_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b want 0", frame_err);
        end
        if (frame_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", frame_count);
        end
        if (params_out !== '0 || rd_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_banks: rd_data %h params_out nonzero=%b", rd_data,
                               |params_out);
        end
    endtask

    task automatic test_basic_commit();
        fill_frame(8'h00);
        send_frame(-1);
        pulse_pc();
        n_checks += 2;
        if (commit_pulse !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL basic_pending: commit %b err %b want 0 0", commit_pulse,
                               frame_err);
        end
        if (params_out !== '0) begin
            n_fail++; $display("FAIL basic_no_early: params_out changed before vsync");
        end
        pulse_vsync();
        exp_active = pack_frame();
        n_checks += 4;
        if (commit_pulse !== 1'b1) begin
            n_fail++; $display("FAIL basic_commit: got %b want 1", commit_pulse);
        end
        if (params_out[87:80] !== 8'h0A) begin
            n_fail++; $display("FAIL basic_byte10: got %h want 0a", params_out[87:80]);
        end
        if (frame_count !== 8'd1 || params_valid !== 1'b1) begin
            n_fail++; $display("FAIL basic_count: count %0d valid %b want 1 1", frame_count,
                               params_valid);
        end
        if (params_out !== exp_active) begin
            n_fail++; $display("FAIL basic_bank: params_out differs from frame");
        end
        cycle();
        n_checks++;
        if (commit_pulse !== 1'b0) begin
            n_fail++; $display("FAIL basic_pulse_width: got %b want 0", commit_pulse);
        end
    endtask

    task automatic test_read();
        rd_addr = IW'(3);
        cycle();
        n_checks++;
        if (rd_data !== 8'h03) begin
            n_fail++; $display("FAIL read_addr3: got %h want 03", rd_data);
        end
        rd_addr = IW'(60);
        cycle();
        n_checks++;
        if (rd_data !== 8'h00) begin
            n_fail++; $display("FAIL read_addr60: got %h want 00", rd_data);
        end
        rd_addr = IW'(10);
        cycle();
        n_checks++;
        if (rd_data !== 8'h0A) begin
            n_fail++; $display("FAIL read_addr10: got %h want 0a", rd_data);
        end
    endtask

    task automatic test_pending_drop();
        fill_frame(8'h40);
        send_frame(-1);
        pulse_pc();
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++; $display("FAIL drop_pre: got %b want 0", frame_err);
        end
        repeat (3) cycle();
        send_byte(0, 8'hFF);
        send_byte(5, 8'hEE);
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_fail++; $display("FAIL drop_err: got %b want 1", frame_err);
        end
        pulse_vsync();
        exp_active = pack_frame();
        n_checks += 3;
        if (commit_pulse !== 1'b1 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL drop_commit: commit %b err %b want 1 0", commit_pulse,
                               frame_err);
        end
        if (params_out !== exp_active) begin
            n_fail++; $display("FAIL drop_bank: byte0 %h want %h", params_out[7:0],
                               exp_active[7:0]);
        end
        if (frame_count !== 8'd2) begin
            n_fail++; $display("FAIL drop_count: got %0d want 2", frame_count);
        end
    endtask

    task automatic test_skip();
        fill_frame(8'h20);
        send_frame(7);
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++; $display("FAIL skip_pre: got %b want 0", frame_err);
        end
        pulse_pc();
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_fail++; $display("FAIL skip_err: got %b want 1", frame_err);
        end
        pulse_vsync();
        n_checks += 2;
        if (commit_pulse !== 1'b0) begin
            n_fail++; $display("FAIL skip_commit: got %b want 0", commit_pulse);
        end
        if (params_out !== exp_active || frame_count !== 8'd2) begin
            n_fail++; $display("FAIL skip_bank: byte0 %h want %h count %0d want 2",
                               params_out[7:0], exp_active[7:0], frame_count);
        end
    endtask

    task automatic test_vsync_coincident();
        fill_frame(8'h60);
        send_frame(-1);
        pc_ready = 1'b1;
        vsync    = 1'b1;
        cycle();
        pc_ready = 1'b0;
        vsync    = 1'b0;
        cycle();
        n_checks++;
        if (commit_pulse !== 1'b0 || frame_count !== 8'd2) begin
            n_fail++; $display("FAIL coinc_nocommit: commit %b count %0d want 0 2",
                               commit_pulse, frame_count);
        end
        pulse_vsync();
        exp_active = pack_frame();
        n_checks += 2;
        if (commit_pulse !== 1'b1 || frame_count !== 8'd3) begin
            n_fail++; $display("FAIL coinc_commit: commit %b count %0d want 1 3",
                               commit_pulse, frame_count);
        end
        if (frame_err !== 1'b0 || params_out !== exp_active) begin
            n_fail++; $display("FAIL coinc_state: err %b byte0 %h want 0 %h", frame_err,
                               params_out[7:0], exp_active[7:0]);
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 253; k++) begin
            fill_frame(8'(k));
            send_frame(-1);
            pulse_pc();
            pulse_vsync();
        end
        exp_active = pack_frame();
        n_checks += 2;
        if (frame_count !== 8'd0 || params_valid !== 1'b1) begin
            n_fail++; $display("FAIL wrap_count: count %0d valid %b want 0 1", frame_count,
                               params_valid);
        end
        if (params_out !== exp_active) begin
            n_fail++; $display("FAIL wrap_bank: byte0 %h want %h", params_out[7:0],
                               exp_active[7:0]);
        end
    endtask

    task automatic test_restart();
        fill_frame(8'h11);
        for (int i = 0; i < 10; i++) send_byte(i, frm[i]);
        fill_frame(8'h99);
        send_frame(-1);
        pulse_pc();
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++; $display("FAIL restart_err: got %b want 0", frame_err);
        end
        pulse_vsync();
        exp_active = pack_frame();
        n_checks++;
        if (commit_pulse !== 1'b1 || params_out !== exp_active || frame_count !== 8'd1) begin
            n_fail++; $display("FAIL restart_commit: commit %b byte9 %h want %h count %0d",
                               commit_pulse, params_out[79:72], exp_active[79:72], frame_count);
        end
    endtask

    task automatic test_idle_events();
        pulse_vsync();
        n_checks++;
        if (commit_pulse !== 1'b0 || frame_count !== 8'd1) begin
            n_fail++; $display("FAIL idle_vsync: commit %b count %0d want 0 1", commit_pulse,
                               frame_count);
        end
        pulse_pc();
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_fail++; $display("FAIL idle_pc: got %b want 1", frame_err);
        end
    endtask

    task automatic test_checksum();
        fill_frame(8'h33);
        send_frame(-1);
        pulse_pc();
        pulse_vsync();
        exp_active = pack_frame();
        n_checks++;
        if (commit_pulse !== 1'b1 || frame_count !== 8'd2 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL csum_good: commit %b count %0d err %b want 1 2 0",
                               commit_pulse, frame_count, frame_err);
        end
        fill_frame(8'h50);
        frm[NB-1] = frm[NB-1] ^ 8'h5A;
        send_frame(-1);
        pulse_pc();
        pulse_vsync();
`ifdef PARAM_CSUM_EN
        n_checks++;
        if (commit_pulse !== 1'b0 || frame_err !== 1'b1 || params_out !== exp_active) begin
            n_fail++; $display("FAIL csum_bad: commit %b err %b want 0 1", commit_pulse,
                               frame_err);
        end
`else
        exp_active = pack_frame();
        n_checks++;
        if (commit_pulse !== 1'b1 || frame_count !== 8'd3 || params_out !== exp_active) begin
            n_fail++; $display("FAIL plain_last: commit %b count %0d want 1 3", commit_pulse,
                               frame_count);
        end
`endif
    endtask

    task automatic test_reset_mid();
        fill_frame(8'h77);
        for (int i = 0; i < 5; i++) send_byte(i, frm[i]);
        do_reset();
        n_checks++;
        if (params_out !== '0 || params_valid !== 1'b0 || frame_count !== 8'd0 ||
            frame_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: valid %b count %0d err %b want 0 0 0",
                               params_valid, frame_count, frame_err);
        end
        // Index 5 continuing the lost frame must be rejected from the idle state.
        send_byte(5, frm[5]);
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_idle: got %b want 1", frame_err);
        end
    endtask

    initial begin
        cycle();
        test_reset();
        test_basic_commit();
        test_read();
        test_pending_drop();
        test_skip();
        test_vsync_coincident();
        test_wrap();
        test_restart();
        test_idle_events();
        test_checksum();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
